adc_reader: RTL and testbench

Responder side of the control loop's ADC handshake: on `arm` it optionally pulses the converter's CNV line, clocks one ADC_WID-bit two's-complement sample out of the ADC over a receive-only SPI link, and presents it on `measured_value` with `finished`. It sits between the control loop (`adc_arm`/`adc_conv`/`adc_finished`/`measured_value`) and the ADC pins, and also serves stand-alone ADC reads from the kernel interface.

---
 rtl/adc_reader_pkg.sv | 21 ++
 rtl/spi_master_rx.sv | 76 +++++++
 rtl/adc_reader.sv | 85 ++++++++
 tb/tb_adc_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_reader_pkg.sv
// Shared definitions for the ADC read path: state encodings and the defaults
// that the control loop also uses for sample width and converter busy time.
package adc_reader_pkg;

  localparam int unsigned ADC_WID_DEFAULT     = 18;
  localparam int unsigned CONV_CYCLES_DEFAULT = 100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_SHIFT,
    ST_DONE
  } adc_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_DONE
  } rx_state_t;

endpackage

// File: rtl/spi_master_rx.sv
// Receive-only SPI master: generates SCK, samples MISO MSB first on the
// selected edge and holds the word with an arm/finished handshake.
module spi_master_rx
  import adc_reader_pkg::*;
#(
  parameter int unsigned DATA_WID = 18,
  parameter int unsigned CNT_WID  = 5,
  parameter int unsigned SCK_HALF = 2,
  parameter bit          POLARITY = 1'b1,
  parameter bit          PHASE    = 1'b0
) (
  input  logic                clk,
  input  logic                rst_L,
  input  logic                arm,
  output logic                finished,
  output logic [DATA_WID-1:0] data,
  output logic                last_edge,
  output logic                sck,
  input  logic                miso
);

  localparam int unsigned HC_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  rx_state_t           state, state_nx;
  logic [HC_W-1:0]     half_cnt;
  logic [CNT_WID-1:0]  bit_cnt;
  logic [DATA_WID-1:0] shreg;
  logic                tick, leading, sample, finished_d;

  // The SCK level before a toggle tells leading (leaving idle) from trailing.
  always_comb begin
    tick      = (state == RX_SHIFT) && (half_cnt == HC_W'(SCK_HALF - 1));
    leading   = (sck == POLARITY);
    sample    = tick && (leading ^ PHASE);
    last_edge = tick && !leading && (bit_cnt == CNT_WID'(DATA_WID - 1));
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RX_IDLE:  if (arm) state_nx = RX_SHIFT;
      RX_SHIFT: if (last_edge) state_nx = RX_DONE;
      RX_DONE:  if (!arm) state_nx = RX_IDLE;
      default:  state_nx = RX_IDLE;
    endcase
  end

  always_comb begin
    finished_d = (state_nx == RX_DONE);
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state    <= RX_IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      sck      <= POLARITY;
      finished <= 1'b0;
      data     <= '0;
    end else begin
      state    <= state_nx;
      finished <= finished_d;
      if (state != RX_SHIFT) half_cnt <= '0;
      else if (tick)         half_cnt <= '0;
      else                   half_cnt <= half_cnt + 1'b1;
      if (tick) sck <= ~sck;
      if (state != RX_SHIFT)     bit_cnt <= '0;
      else if (tick && !leading) bit_cnt <= bit_cnt + 1'b1;
      if (sample) shreg <= {shreg[DATA_WID-2:0], miso};
      // With trailing-edge sampling the final bit arrives on the closing edge.
      if (last_edge) data <= PHASE ? {shreg[DATA_WID-2:0], miso} : shreg;
    end
  end

endmodule

// File: rtl/adc_reader.sv
// ADC responder: optional CNV pulse of CONV_CYCLES clocks, then a serial read
// through spi_master_rx; the sample is held on measured_value with finished.
module adc_reader
  import adc_reader_pkg::*;
#(
  parameter int unsigned ADC_WID      = ADC_WID_DEFAULT,
  parameter int unsigned WID_SIZ      = 5,
  parameter int unsigned CONV_CYCLES  = CONV_CYCLES_DEFAULT,
  parameter int unsigned CONV_WID     = 8,
  parameter int unsigned SCK_HALF     = 2,
  parameter bit          ADC_POLARITY = 1'b1,
  parameter bit          ADC_PHASE    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_L,
  input  logic                      arm,
  input  logic                      conv,
  output logic                      finished,
  output logic signed [ADC_WID-1:0] measured_value,
  output logic                      cnv,
  output logic                      sck,
  input  logic                      miso
);

  adc_state_t          state, state_nx;
  logic [CONV_WID-1:0] conv_cnt;
  logic                conv_last, cnv_d, rx_arm, rx_last;

  assign conv_last = (state == ST_CONVERT) && (conv_cnt == CONV_WID'(CONV_CYCLES - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:    if (arm) state_nx = conv ? ST_CONVERT : ST_SHIFT;
      ST_CONVERT: if (conv_last) state_nx = ST_SHIFT;
      ST_SHIFT:   if (rx_last) state_nx = ST_DONE;
      ST_DONE:    if (!arm) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // The receiver is started on the same edge this FSM enters SHIFT, and then
  // follows the external arm so both FSMs leave DONE together.
  always_comb begin
    cnv_d  = (state_nx == ST_CONVERT);
    rx_arm = 1'b0;
    unique case (state)
      ST_IDLE:    rx_arm = arm && !conv;
      ST_CONVERT: rx_arm = conv_last;
      ST_SHIFT,
      ST_DONE:    rx_arm = arm;
      default:    rx_arm = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state    <= ST_IDLE;
      conv_cnt <= '0;
      cnv      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnv      <= cnv_d;
      conv_cnt <= (state == ST_CONVERT) ? conv_cnt + 1'b1 : '0;
    end
  end

  spi_master_rx #(
    .DATA_WID (ADC_WID),
    .CNT_WID  (WID_SIZ),
    .SCK_HALF (SCK_HALF),
    .POLARITY (ADC_POLARITY),
    .PHASE    (ADC_PHASE)
  ) u_rx (
    .clk       (clk),
    .rst_L     (rst_L),
    .arm       (rx_arm),
    .finished  (finished),
    .data      (measured_value),
    .last_edge (rx_last),
    .sck       (sck),
    .miso      (miso)
  );

endmodule

// File: tb/tb_adc_reader.sv
// Bench for adc_reader: four instances covering every SCK polarity/phase pair,
// each fed by an SPI ADC model that shifts a chosen word out MSB first.
module tb_adc_reader;

  localparam int W = 18;
  localparam int H = 2;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_L = 1'b0;
  logic arm = 1'b0;
  logic conv = 1'b0;
  logic [W-1:0] pattern = '0;

  logic [3:0] fin, cnv_o, sck_o, miso_i;
  logic signed [W-1:0] mv [4];
  int unsigned lead_w [4];
  int unsigned trail_w [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic bit pol_of(input int i);
    return i < 2;
  endfunction

  // Reference value: the transmitted word read as two's complement.
  function automatic logic signed [63:0] sext(input logic [W-1:0] p);
    logic signed [W-1:0] s;
    s = p;
    return s;
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_ch
    localparam bit POL = (i < 2);
    localparam bit PHA = (i % 2 == 1);

    adc_reader #(
      .ADC_WID      (W),
      .WID_SIZ      (5),
      .CONV_CYCLES  (C),
      .CONV_WID     (8),
      .SCK_HALF     (H),
      .ADC_POLARITY (POL),
      .ADC_PHASE    (PHA)
    ) u_dut (
      .clk            (clk),
      .rst_L          (rst_L),
      .arm            (arm),
      .conv           (conv),
      .finished       (fin[i]),
      .measured_value (mv[i]),
      .cnv            (cnv_o[i]),
      .sck            (sck_o[i]),
      .miso           (miso_i[i])
    );

    // ADC model: phase 0 presents the MSB up front and advances after each
    // trailing edge; phase 1 presents the next bit after each leading edge.
    logic m = 1'b0;
    logic arm_s = 1'b0;
    logic prev_arm = 1'b0;
    logic prev_sck = POL;
    int unsigned idx = 0;
    int unsigned lead = 0;
    int unsigned trail = 0;

    always @(posedge clk) arm_s <= arm;

    always @(negedge clk) begin
      if (!rst_L) begin
        idx = 0;
        prev_sck = POL;
        prev_arm = 1'b0;
      end else begin
        if (arm_s && !prev_arm) begin
          idx = 0;
          m = PHA ? 1'($urandom) : pattern[W-1];
        end
        if (sck_o[i] != prev_sck) begin
          if (sck_o[i] != POL) begin
            lead++;
            if (PHA && idx < W) begin
              m = pattern[5'(W - 1 - idx)];
              idx++;
            end
          end else begin
            trail++;
            if (!PHA) begin
              idx++;
              if (idx < W) m = pattern[5'(W - 1 - idx)];
            end
          end
        end
        prev_sck = sck_o[i];
        prev_arm = arm_s;
      end
    end

    assign miso_i[i]  = m;
    assign lead_w[i]  = lead;
    assign trail_w[i] = trail;
  end

  task automatic check(input string tag, input int ch,
                       input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, ch, obs, exp);
    end
  endtask

  // Called just after a negedge. Runs one transaction; drop_at>0 releases arm
  // in that cycle, hold keeps arm high that many cycles after finished.
  task automatic run_txn(input logic c, input logic [W-1:0] pat,
                         input int hold, input int drop_at);
    int n = 0;
    int exp_lat;
    int cnv_cnt [4];
    int cnv_first [4];
    int early [4];
    int unsigned lead0 [4];
    int unsigned trail0 [4];
    logic signed [W-1:0] prev [4];
    bit done = 1'b0;

    exp_lat = 1 + (c ? C : 0) + 2 * W * H;
    pattern = pat;
    conv = c;
    arm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lead0[i] = lead_w[i];
      trail0[i] = trail_w[i];
      prev[i] = mv[i];
      cnv_cnt[i] = 0;
      cnv_first[i] = 0;
      early[i] = 0;
    end

    while (!done && n < exp_lat + 20) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 4; i++) begin
        if (cnv_o[i] === 1'b1) begin
          cnv_cnt[i]++;
          if (cnv_first[i] == 0) cnv_first[i] = n;
        end
      end
      if (fin[0] === 1'b1) done = 1'b1;
      else for (int i = 0; i < 4; i++) if (mv[i] !== prev[i]) early[i]++;
      if (n == drop_at) arm = 1'b0;
    end

    check("finished_seen", 0, done, 1);
    if (!done) begin
      arm = 1'b0;
      return;
    end
    check("latency", 0, n, exp_lat);
    for (int i = 0; i < 4; i++) begin
      check("cnv_cycles", i, cnv_cnt[i], c ? C : 0);
      check("cnv_start", i, cnv_first[i], c ? 1 : 0);
      check("value_stable_in_flight", i, early[i], 0);
      check("finished", i, fin[i], 1);
      check("value", i, mv[i], sext(pat));
      check("sck_idle", i, sck_o[i], pol_of(i));
    end

    repeat (hold) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        check("done_hold", i, fin[i], 1);
        check("hold_value", i, mv[i], sext(pat));
      end
    end

    arm = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("finished_low", i, fin[i], 0);
      check("lead_edges", i, lead_w[i] - lead0[i], W);
      check("trail_edges", i, trail_w[i] - trail0[i], W);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_value", i, mv[i], 0);
      check("rst_finished", i, fin[i], 0);
      check("rst_cnv", i, cnv_o[i], 0);
      check("rst_sck", i, sck_o[i], pol_of(i));
    end
    rst_L = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 18'h2A5C3, 3, 0);
    run_txn(1'b0, 18'h1FFFF, 0, 0);
    run_txn(1'b1, 18'h20001, 1, 0);
    run_txn(1'b0, 18'h0C3A5, 0, 11);
    run_txn(1'b1, 18'h00000, 0, 0);
    run_txn(1'b1, 18'h3FFFF, 0, 0);

    // Reset in the middle of bit 9 of a read-only transaction.
    pattern = 18'h155AA;
    conv = 1'b0;
    arm = 1'b1;
    repeat (38) @(negedge clk);
    rst_L = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("midrst_sck", i, sck_o[i], pol_of(i));
      check("midrst_cnv", i, cnv_o[i], 0);
      check("midrst_finished", i, fin[i], 0);
      check("midrst_value", i, mv[i], 0);
    end
    repeat (3) @(negedge clk);
    rst_L = 1'b1;
    arm = 1'b0;
    @(negedge clk);
    run_txn(1'b0, 18'h0F0F0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      run_txn(1'($urandom), W'($urandom), int'($urandom_range(0, 2)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
